imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Pipelined, XLEN-parametrised immediate generator for the decode stage.
- Accepts an instruction slice plus an immediate-format select on a valid/ready interface.
- Produces a registered, sign- or zero-extended immediate with a sideband tag.
- Contains a 2-entry skid buffer so downstream stalls never drop data and in_ready is fully registered.
- Adds CSR zimm and shift-amount formats, plus flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of sideband tag carried alongside the immediate (e.g. rd index).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  block can accept this cycle.
- instr  input  25  instruction bits [31:7].
- immsrc  input  3  format select.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  immext/out_tag valid.
- out_ready  input  1  downstream accepts.
- immext  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag matching immext.

Behaviour:
- immsrc encodings. Sign extension is from instr[31] to full XLEN.
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 100 U: sext({instr[31:12], 12'b0}); at XLEN=64 the upper 32 bits copy instr[31].
  - 101 Z: zero-extended instr[19:15] (CSR zimm).
  - 110 SH: zero-extended shamt; instr[24:20] at XLEN=32, instr[25:20] at XLEN=64.
  - 111: immext=0.
- Storage: main output register (M) and skid register (K), each holding {valid, imm, tag}.
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !K.valid. It is a register output with no combinational path from out_ready.
- Latency: 1 cycle. A value accepted in cycle N with M empty, or draining in N, appears on outputs in N+1.
- Next-state rules, in priority order:
  - flush=1: M.valid←0, K.valid←0. Any concurrent accept is discarded. Data fields hold.
  - M empty or draining:
    - If K.valid, K moves to M and K.valid←0.
    - Else, if accept, the new entry loads M.
    - An accept while K.valid is impossible.
  - M full and not draining: an accept loads K.
- Ordering: strict FIFO order is maintained, including K→M with a simultaneous accept in the same cycle. That case is impossible because in_ready=0 whenever K.valid.
- out_valid=M.valid. immext/out_tag are driven from M and are held stable while out_valid & !out_ready.
- Reset (async assert, sync-released by top level):
  - M.valid=0, K.valid=0, immext=0, out_tag=0.
  - out_valid=0, in_ready=1.
- Reset mid-transfer drops all entries, with no partial output.
- XLEN other than 32/64 is a parameter error (elaboration-time check).

Optional Feature:
- Macro IMMGEN_ILLEGAL_EN.
- When defined:
  - Adds output port illegal (1 bit), stored per entry and travelling with M/K.
  - illegal=1 when immsrc=111, or when immsrc=110 at XLEN=32 with instr[25]=1.
  - immext=0 for those cases.
  - Reset value of illegal is 0.
- When undefined, the port is absent and those cases silently produce 0, or the truncated shamt for the SH case.

Decomposition:
- Shared package imm_pkg holds:
  - immsrc localparams IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_NONE.
  - XLEN legality constants.
- One natural sub-module: imm_decode, a purely combinational XLEN-parametrised format mux feeding the M/K registers.
- Skid buffer control stays in imm_gen_pipe.

Test Plan:
- XLEN=32, immsrc=000, instr[31:20]=0xFFF, out_ready=1 → next cycle out_valid=1, immext=0xFFFFFFFF, in_ready stays 1.
- XLEN=64, immsrc=100, instr[31:12]=0x80000 → immext=0xFFFFFFFF80000000. Also immsrc=010 for encoding of branch offset −4 → immext=0xFFFFFFFFFFFFFFFC.
- Back-pressure: out_ready=0, send tags 1,2 on consecutive cycles → in_ready=0 after tag 2; tag 3 held off. Then out_ready=1 → tags drain in order 1,2,3 with no loss or duplication.
- flush while M and K both valid and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input is never output.
- Async reset asserted mid-stall → out_valid=0, immext=0, in_ready=1 immediately, without waiting for a clock edge.
- With IMMGEN_ILLEGAL_EN, immsrc=111 → illegal=1, immext=0. With immsrc=101 and instr[19:15]=0x1F → immext=0x1F, illegal=0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: format selects and XLEN legality.
package imm_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_Z    = 3'b101;
  localparam logic [2:0] IMM_SH   = 3'b110;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate format mux; IMMGEN_ILLEGAL_EN adds the illegal flag and zeroes
// the immediate for unsupported formats.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [24:0]     instr_i,
  input  logic [2:0]      immsrc_i,
`ifdef IMMGEN_ILLEGAL_EN
  output logic            illegal_o,
`endif
  output logic [XLEN-1:0] imm_o
);

  // Re-index the slice so field selects read like the architectural encoding.
  logic [31:7]     ir;
  logic [XLEN-1:0] ext;

  assign ir = instr_i;

  always_comb begin
    ext = '0;
    case (immsrc_i)
      IMM_I:  ext = XLEN'($signed(ir[31:20]));
      IMM_S:  ext = XLEN'($signed({ir[31:25], ir[11:7]}));
      IMM_B:  ext = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      IMM_J:  ext = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      IMM_U:  ext = XLEN'($signed({ir[31:12], 12'b0}));
      IMM_Z:  ext = XLEN'(ir[19:15]);
      IMM_SH: begin
        if (XLEN == XLEN_64) ext = XLEN'(ir[25:20]);
        else                 ext = XLEN'(ir[24:20]);
      end
      default: ext = '0;
    endcase
  end

`ifdef IMMGEN_ILLEGAL_EN
  // A 6-bit shift amount cannot be honoured on a 32-bit datapath.
  assign illegal_o = (immsrc_i == IMM_NONE) ||
                     ((immsrc_i == IMM_SH) && (XLEN == XLEN_32) && ir[25]);
  assign imm_o     = illegal_o ? '0 : ext;
`else
  assign imm_o     = ext;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (M output reg + K skid reg).
// Optional IMMGEN_ILLEGAL_EN adds a per-entry illegal output.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
`ifdef IMMGEN_ILLEGAL_EN
  output logic             illegal,
`endif
  output logic [TAG_W-1:0] out_tag
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic             valid;
`ifdef IMMGEN_ILLEGAL_EN
    logic             illegal;
`endif
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          m_q, m_d, k_q, k_d, new_e;
  logic [XLEN-1:0] dec_imm;
  logic            accept, drain;
`ifdef IMMGEN_ILLEGAL_EN
  logic            dec_illegal;
`endif

  imm_decode #(
    .XLEN(XLEN)
  ) u_imm_decode (
    .instr_i  (instr),
    .immsrc_i (immsrc),
`ifdef IMMGEN_ILLEGAL_EN
    .illegal_o(dec_illegal),
`endif
    .imm_o    (dec_imm)
  );

  always_comb begin
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.imm   = dec_imm;
    new_e.tag   = in_tag;
`ifdef IMMGEN_ILLEGAL_EN
    new_e.illegal = dec_illegal;
`endif
  end

  // in_ready comes straight from K so out_ready never reaches it combinationally.
  assign in_ready = ~k_q.valid;
  assign accept   = in_valid & in_ready;
  assign drain    = m_q.valid & out_ready;

  always_comb begin
    m_d = m_q;
    k_d = k_q;
    if (flush) begin
      m_d.valid = 1'b0;
      k_d.valid = 1'b0;
    end else if (!m_q.valid || drain) begin
      if (k_q.valid) begin
        m_d       = k_q;
        k_d.valid = 1'b0;
      end else if (accept) begin
        m_d = new_e;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (accept) begin
      k_d = new_e;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q <= '0;
      k_q <= '0;
    end else begin
      m_q <= m_d;
      k_q <= k_d;
    end
  end

  assign out_valid = m_q.valid;
  assign immext    = m_q.imm;
  assign out_tag   = m_q.tag;
`ifdef IMMGEN_ILLEGAL_EN
  assign illegal   = m_q.illegal;
`endif

endmodule
